// File: rtl/tm_host_driver.sv
// tm_host_driver: buffers host words and strobes them into the TM chip.
// Sends Next/Done handshakes and captures the display word on Compute_done.
module tm_host_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [5:0]  tm_data,
  output logic        tm_next,
  output logic        tm_done,
  input  logic        tm_compute_done,
  input  logic [10:0] tm_display,
  output logic [10:0] result,
  output logic        result_valid,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE_STROBE,
    WAIT_RESULT
  } state_t;

  state_t state, state_n;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic [6:0]    head;

  logic [7:0]    cnt, cnt_n;
  logic          phase_end;
  logic          last_q;
  logic          cap;

  logic          s1, s2, s3;
  logic          cd_rise;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign head     = mem[rd_ptr];
  assign cd_rise  = s2 & ~s3;
  assign busy     = (state != IDLE) | (count != '0);

  // Word storage; contents need no reset, occupancy tracks validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // Pointers wrap naturally; occupancy separates full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

  // Compute_done crosses in through two flops, third flop finds the rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tm_compute_done;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Phase sequencing; counter reloads whenever the state changes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pop       = 1'b0;
    cap       = 1'b0;
    phase_end = (cnt == 8'd0);
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) state_n = PULSE;
      end
      PULSE: begin
        if (phase_end) state_n = GAP;
      end
      GAP: begin
        if (phase_end) state_n = last_q ? DONE_STROBE : IDLE;
      end
      DONE_STROBE: begin
        if (phase_end) state_n = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (cd_rise) begin
          cap     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = HOLD_M1;
    else if (!phase_end) cnt_n = cnt - 8'd1;
  end

  // State, held data and registered strobes toward the chip.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      last_q       <= 1'b0;
      tm_data      <= 6'd0;
      tm_next      <= 1'b0;
      tm_done      <= 1'b0;
      result       <= 11'd0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tm_next      <= (state_n == PULSE);
      tm_done      <= (state_n == DONE_STROBE);
      result_valid <= cap;
      if (pop) begin
        tm_data <= head[5:0];
        last_q  <= head[6];
      end
      if (cap) result <= tm_display;
    end
  end

endmodule

// File: tb/tb_tm_host_driver.sv
// tb_tm_host_driver: directed stimulus with a word-level reference model.
// Every cycle the DUT outputs are compared against the model.
module tb_tm_host_driver;

  localparam int H = 4;
  localparam int D = 8;

  logic        clock;
  logic        reset;
  logic [5:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  tm_data;
  logic        tm_next;
  logic        tm_done;
  logic        tm_compute_done;
  logic [10:0] tm_display;
  logic [10:0] result;
  logic        result_valid;
  logic        busy;

  tm_host_driver #(.HOLD_CYCLES(H), .FIFO_DEPTH(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .tm_data         (tm_data),
    .tm_next         (tm_next),
    .tm_done         (tm_done),
    .tm_compute_done (tm_compute_done),
    .tm_display      (tm_display),
    .result          (result),
    .result_valid    (result_valid),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: queue of words, one word in flight timed by edges since pop.
  logic [6:0]  mq[$];
  bit          active = 0;
  int          k = 0;
  bit          m_last = 0;
  logic [5:0]  m_data = 0;
  logic [10:0] m_res = 0;
  bit          m_rv = 0;
  bit          h1 = 0, h2 = 0, h3 = 0;

  always @(posedge clock) begin
    bit rise, pop_ok, push_ok;
    logic [6:0] w;
    if (reset) begin
      mq.delete();
      active = 0; k = 0; m_last = 0; m_data = 0;
      m_res = 0; m_rv = 0; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      rise = h2 && !h3;
      h3 = h2; h2 = h1; h1 = tm_compute_done;
      pop_ok = !active && mq.size() > 0;
      push_ok = in_valid && mq.size() < D;
      m_rv = 0;
      if (active) begin
        if (m_last && k >= 4 * H) begin
          if (rise) begin
            m_res = tm_display; m_rv = 1; active = 0;
          end
        end else begin
          k++;
          if (!m_last && k == 3 * H) active = 0;
        end
      end
      if (pop_ok) begin
        w = mq.pop_front();
        m_data = w[5:0]; m_last = w[6]; active = 1; k = 0;
      end
      if (push_ok) mq.push_back({in_last, in_data});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (en) begin
      chk("tm_data", tm_data, m_data);
      chk("tm_next", tm_next, active && k >= H && k < 2 * H);
      chk("tm_done", tm_done,
          active && m_last && k >= 3 * H && k < 4 * H);
      chk("busy", busy, active || mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < D);
      chk("result", result, m_res);
      chk("result_valid", result_valid, m_rv);
    end
  end

  // Log of words actually strobed into the chip.
  logic [5:0] sent[$];
  logic [5:0] exp_sent[$];
  bit pn = 0;
  always @(negedge clock) begin
    if (en && tm_next && !pn) sent.push_back(tm_data);
    pn = tm_next;
  end

  task automatic push(input logic [5:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    int n, dcnt, ns;
    bit ok, seen;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    tm_compute_done = 1'b0; tm_display = '0;
    @(negedge clock);
    en = 1;
    chk("rst_tm_data", tm_data, 0);
    chk("rst_tm_next", tm_next, 0);
    chk("rst_tm_done", tm_done, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // single word, not last
    push(6'h15, 1'b0);
    exp_sent.push_back(6'h15);
    @(negedge clock);
    chk("w15_setup_data", tm_data, 6'h15);
    chk("w15_setup_next", tm_next, 0);
    repeat (4) @(negedge clock);
    chk("w15_pulse_first", tm_next, 1);
    repeat (3) @(negedge clock);
    chk("w15_pulse_last", tm_next, 1);
    @(negedge clock);
    chk("w15_gap", tm_next, 0);
    repeat (3) @(negedge clock);
    chk("w15_gap_end_busy", busy, 1);
    @(negedge clock);
    chk("w15_idle_busy", busy, 0);

    // three-word transfer ending in Done, then result capture
    in_valid = 1'b1; in_data = 6'h01; in_last = 1'b0;
    @(negedge clock); in_data = 6'h02;
    @(negedge clock); in_data = 6'h03; in_last = 1'b1;
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
    exp_sent.push_back(6'h01);
    exp_sent.push_back(6'h02);
    exp_sent.push_back(6'h03);
    ok = 0; dcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tm_done) begin
        dcnt++;
        if (dcnt == 1) chk("done_data", tm_data, 6'h03);
      end else if (dcnt > 0) begin
        ok = 1;
        break;
      end
    end
    chk("done_reached", ok, 1);
    chk("done_len", dcnt, 4);
    tm_display = 11'h5A5; tm_compute_done = 1'b1;
    @(negedge clock); chk("rv_c1", result_valid, 0);
    @(negedge clock); chk("rv_c2", result_valid, 0);
    @(negedge clock); chk("rv_c3", result_valid, 1);
    chk("result_5a5", result, 11'h5A5);
    @(negedge clock); chk("rv_c4", result_valid, 0);
    tm_compute_done = 1'b0;

    // Compute_done while idle must be ignored
    tm_display = 11'h123;
    repeat (2) @(negedge clock);
    tm_compute_done = 1'b1;
    seen = 0;
    repeat (3) begin @(negedge clock); if (result_valid) seen = 1; end
    tm_compute_done = 1'b0;
    repeat (4) begin @(negedge clock); if (result_valid) seen = 1; end
    chk("idle_cd_rv", seen, 0);
    chk("idle_cd_result", result, 11'h5A5);

    // stall in Done/Wait, fill buffer, then push+pop at occupancy 7
    push(6'h3F, 1'b1);
    exp_sent.push_back(6'h3F);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (tm_done) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("stall_reached", ok, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) break;
      in_valid = 1'b1; in_last = 1'b0; in_data = 6'(32 + n);
      exp_sent.push_back(6'(32 + n));
      n++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("fill_count", n, 8);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 6'h3E;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    chk("full_busy", busy, 1);
    tm_display = 11'h2AA; tm_compute_done = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (result_valid) begin ok = 1; break; end
    end
    chk("release_rv", ok, 1);
    chk("release_result", result, 11'h2AA);
    tm_compute_done = 1'b0;
    repeat (13) @(negedge clock);
    chk("occ7_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 6'h30; in_last = 1'b0;
    exp_sent.push_back(6'h30);
    @(negedge clock);
    in_valid = 1'b0;
    chk("occ7_after_ready", in_ready, 1);
    chk("occ7_pop_data", tm_data, 6'h21);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1; break; end
    end
    chk("drained", ok, 1);

    // reset in the second Next cycle with three words queued
    in_valid = 1'b1; in_data = 6'h0A;
    @(negedge clock); in_data = 6'h0B;
    @(negedge clock); in_data = 6'h0C;
    @(negedge clock); in_data = 6'h0D;
    @(negedge clock); in_valid = 1'b0;
    exp_sent.push_back(6'h0A);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (tm_next) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("rst_pulse_reached", ok, 1);
    @(negedge clock);
    chk("rst_pulse2", tm_next, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_next", tm_next, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 1);
    reset = 1'b0;
    ns = sent.size();
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (tm_next || tm_done) seen = 1;
    end
    chk("rst_no_strobe", seen, 0);
    chk("rst_no_send", sent.size(), ns);

    chk("sent_count", sent.size(), exp_sent.size());
    for (int i = 0; i < exp_sent.size() && i < sent.size(); i++)
      chk($sformatf("sent_%0d", i), sent[i], exp_sent[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tm_host_driver.md
TM_HOST_DRIVER -- requirements
Module: tm_host_driver

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles per SETUP, PULSE, GAP and DONE phase; legal range 3..255.
REQ-002 Parameter FIFO_DEPTH, default 8: word-buffer entries; power of two, 2..16.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  6  tape/program symbol to send.
REQ-006 in_last  input  1  marks the final word of a transfer.
REQ-007 in_valid  input  1  producer offers {in_last,in_data}.
REQ-008 in_ready  output  1  buffer can accept a word.
REQ-009 tm_data  output  6  data pins to the Turing-machine chip.
REQ-010 tm_next  output  1  Next strobe to the chip.
REQ-011 tm_done  output  1  Done strobe to the chip.
REQ-012 tm_compute_done  input  1  asynchronous Compute_done from the chip.
REQ-013 tm_display  input  11  display_out from the chip; quasi-static.
REQ-014 result  output  11  captured display word.
REQ-015 result_valid  output  1  one-cycle pulse when result updates.
REQ-016 busy  output  1  high whenever state is not IDLE or the buffer is non-empty.

Function
REQ-017 Buffer: FIFO of FIFO_DEPTH 7-bit entries {last,data}; in_ready = not full; push when in_valid and in_ready.
REQ-018 Simultaneous push and pop on a non-full buffer both take effect; occupancy unchanged.
REQ-019 Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an occupancy count, never by pointer equality alone.
REQ-020 States: IDLE, SETUP, PULSE, GAP, DONE_STROBE, WAIT_RESULT; one phase counter reloads to HOLD_CYCLES-1 on every state entry.
REQ-021 IDLE: if buffer non-empty, pop head, load tm_data and a last flag from it, enter SETUP next cycle; otherwise remain.
REQ-022 SETUP: tm_next=0, tm_data held; after HOLD_CYCLES cycles enter PULSE.
REQ-023 PULSE: tm_next=1 for exactly HOLD_CYCLES cycles; then GAP.
REQ-024 GAP: tm_next=0, tm_data held, HOLD_CYCLES cycles; then DONE_STROBE if the last flag is set, else IDLE.
REQ-025 DONE_STROBE: tm_done=1 for exactly HOLD_CYCLES cycles, tm_data held; then WAIT_RESULT.
REQ-026 tm_data changes only on the IDLE->SETUP transition; tm_next and tm_done are never high together.
REQ-027 Per word, IDLE-to-IDLE takes 3*HOLD_CYCLES+1 cycles.
REQ-028 tm_compute_done passes through a 2-flop synchronizer plus one edge-detect flop; only a synchronized 0->1 edge counts.
REQ-029 WAIT_RESULT: on a detected edge, result <= tm_display sampled that cycle, result_valid=1 for one cycle, then IDLE.
REQ-030 An edge detected in any state other than WAIT_RESULT is ignored; result is unchanged.
REQ-031 Words pushed during DONE_STROBE or WAIT_RESULT stay buffered and are not sent until IDLE is re-entered.
REQ-032 The last flag affects only the word carrying it; a transfer may be a single word.

Reset
REQ-033 When reset is high at a clock edge: state IDLE, buffer empty, counters and synchronizer flops 0.
REQ-034 Reset values: tm_data=0, tm_next=0, tm_done=0, result=0, result_valid=0, busy=0, in_ready=1.
REQ-035 Reset mid-strobe drops tm_next or tm_done low the cycle after the edge and discards all buffered words.

Verification
REQ-036 HOLD_CYCLES=4. Push 0x15 with last=0. Required: tm_data=0x15 for 4 cycles with tm_next=0, then tm_next=1 for 4 cycles, then 4 cycles low; back in IDLE 13 cycles after the pop.
REQ-037 Push 0x01, 0x02, and 0x03 with last=1. Required: three Next pulses in order, then tm_done=1 for 4 cycles with tm_data=0x03, then WAIT_RESULT. Raise tm_compute_done with tm_display=0x5A5. Required: result=0x5A5 and a 1-cycle result_valid exactly 3 cycles later.
REQ-038 Hold in_valid high with the driver stalled. Required: in_ready falls after 8 accepted words. Then, with push and pop in the same cycle at occupancy 7, occupancy stays 7; pointer wrap loses no word.
REQ-039 Pulse tm_compute_done while in IDLE. Required: result and result_valid unchanged.
REQ-040 Assert reset during the 2nd PULSE cycle with 3 words buffered. Required: next cycle tm_next=0, busy=0, in_ready=1; nothing further is sent.
